tc_alu_misr_checker: RTL and testbench

//  Response-compaction and pass/fail stage of the ALU BIST; sits directly downstream of the ALU core.

---
 rtl/tc_alu_misr_checker_pkg.sv | 15 +
 rtl/tc_alu_misr_checker_if.sv | 27 ++
 rtl/tc_alu_misr_checker_misr.sv | 37 +++
 rtl/tc_alu_misr_checker.sv | 97 +++++++++
 tb/tb_tc_alu_misr_checker.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tc_alu_misr_checker_pkg.sv
// Types and defaults shared by the ALU BIST blocks: the LFSR pattern generator, the controller and the MISR checker.
package tc_bist_pkg;

  localparam int               TC_BIST_WIDTH    = 16;
  localparam logic [15:0]      TC_MISR_POLY     = 16'h1021;
  localparam int               TC_BIST_PATTERNS = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CMP     = 2'd2,
    DONE    = 2'd3
  } bist_state_t;

endpackage

// File: rtl/tc_alu_misr_checker_if.sv
// Control, ALU-result, scan and status signals between the BIST environment (master) and the checker (slave).
interface tc_alu_misr_checker_if #(
  parameter int WIDTH = 16
);

  logic             TEST_EN;
  logic             SET_EN;
  logic [WIDTH-1:0] Y;
  logic             SI_EN;
  logic             SI;
  logic             SO;
  logic             PASS_N;
  logic             DONE;
  logic             BUSY;
  logic [WIDTH-1:0] SIG;

  modport master (
    output TEST_EN, SET_EN, Y, SI_EN, SI,
    input  SO, PASS_N, DONE, BUSY, SIG
  );

  modport slave (
    input  TEST_EN, SET_EN, Y, SI_EN, SI,
    output SO, PASS_N, DONE, BUSY, SIG
  );

endinterface

// File: rtl/tc_alu_misr_checker_misr.sv
// Signature register: seed load, MISR compaction of y, or serial scan shift (priority in that order).
module tc_misr16 #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             compact,
  input  logic             shift,
  input  logic [WIDTH-1:0] y,
  input  logic             si,
  output logic [WIDTH-1:0] sig,
  output logic             so
);

  logic [WIDTH-1:0] feedback;

  assign feedback = sig[WIDTH-1] ? POLY : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (compact) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ feedback ^ y;
    end else if (shift) begin
      sig <= {sig[WIDTH-2:0], si};
    end
  end

  // Taken straight from the flop so the scan output never glitches.
  assign so = sig[WIDTH-1];

endmodule

// File: rtl/tc_alu_misr_checker.sv
// BIST response checker: compacts PATTERNS ALU results into a MISR, compares with GOLDEN, reports PASS_N/DONE.
module tc_alu_misr_checker
  import tc_bist_pkg::*;
#(
  parameter int               WIDTH    = TC_BIST_WIDTH,
  parameter int               PATTERNS = TC_BIST_PATTERNS,
  parameter logic [WIDTH-1:0] POLY     = TC_MISR_POLY,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter logic [WIDTH-1:0] GOLDEN   = '0
) (
  input  logic                clk,
  input  logic                RST_N,
  tc_alu_misr_checker_if.slave bus
);

  localparam logic [7:0] LAST_COUNT = 8'(PATTERNS - 1);

  bist_state_t      state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic             pass_q, pass_d;
  logic             load, compact, shift;
  logic [WIDTH-1:0] sig;
  logic             so;

  tc_misr16 #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk     (clk),
    .rst_n   (RST_N),
    .load    (load),
    .compact (compact),
    .shift   (shift),
    .y       (bus.Y),
    .si      (bus.SI),
    .sig     (sig),
    .so      (so)
  );

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= '0;
      pass_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pass_d  = pass_q;
    load    = 1'b0;
    compact = 1'b0;
    shift   = 1'b0;
    // Leaving test mode freezes the signature and verdict; only the FSM drops to IDLE.
    if (!bus.TEST_EN) begin
      state_d = IDLE;
    end else if (bus.SET_EN) begin
      load    = 1'b1;
      count_d = '0;
      pass_d  = 1'b1;
      state_d = COMPACT;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          shift = bus.SI_EN;
        end
        COMPACT: begin
          compact = 1'b1;
          count_d = count_q + 8'd1;
          if (count_q == LAST_COUNT) begin
            state_d = CMP;
          end
        end
        CMP: begin
          pass_d  = (sig != GOLDEN);
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.SIG    = sig;
  assign bus.SO     = so;
  assign bus.PASS_N = pass_q;
  assign bus.DONE   = (state_q == DONE);
  assign bus.BUSY   = (state_q == COMPACT);

endmodule

// File: tb/tb_tc_alu_misr_checker.sv
// Bench for tc_alu_misr_checker: directed runs, DONE results checked by a scoreboard monitor.
module tb_tc_alu_misr_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass_n;
  } exp_t;

  exp_t sb[$];
  logic done_q = 1'b0;

  always #5 clk = ~clk;

  tc_alu_misr_checker_if #(.WIDTH(16)) bus ();

  tc_alu_misr_checker dut (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] model_step(logic [15:0] s, logic [15:0] y);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ y;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one BIST pass; Y = val on compaction edge hit, else 0. Returns the model signature.
  task automatic run_bist(input int hit, input logic [15:0] val, output logic [15:0] m);
    m = 16'h0000;
    bus.SET_EN = 1'b1;
    tick();
    bus.SET_EN = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      bus.Y = (k == hit) ? val : 16'h0000;
      m = model_step(m, bus.Y);
      tick();
      if (k == 6 && hit == 5 && val == 16'h8000) chk("fold_wrap_edge6", bus.SIG, 16'h1021);
    end
    bus.Y = 16'h0000;
    chk("done_low_edge32", bus.DONE, 1'b0);
    sb.push_back('{sig: m, pass_n: (m != 16'h0000)});
    tick();
    chk("done_high_edge33", bus.DONE, 1'b1);
    chk("busy_low_edge33", bus.BUSY, 1'b0);
  endtask

  // Scoreboard monitor: each DONE rising edge pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (bus.DONE && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL done_unexpected: got DONE=1 expected no result pending at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_sig", bus.SIG, e.sig);
        chk("sb_pass_n", bus.PASS_N, e.pass_n);
      end
    end
    done_q = bus.DONE;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m;
    logic [15:0] pat;
    rst_n       = 1'b0;
    bus.TEST_EN = 1'b0;
    bus.SET_EN  = 1'b0;
    bus.Y       = 16'h0000;
    bus.SI_EN   = 1'b0;
    bus.SI      = 1'b0;
    #12;
    chk("rst_pass_n", bus.PASS_N, 1'b1);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_sig", bus.SIG, 16'h0000);
    chk("rst_so", bus.SO, 1'b0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.TEST_EN = 1'b1;

    // Single fold
    bus.SET_EN = 1'b1;
    tick();
    bus.SET_EN = 1'b0;
    chk("seed_busy", bus.BUSY, 1'b1);
    bus.Y = 16'h0001;
    tick();
    chk("fold1_sig", bus.SIG, 16'h0001);
    bus.Y = 16'h0000;
    tick();
    chk("fold2_sig", bus.SIG, 16'h0002);

    // Full pass with SI_EN held high: scan must be ignored while compacting
    bus.SI_EN = 1'b1;
    bus.SI    = 1'b1;
    run_bist(0, 16'h0000, m);
    chk("pass_sig", bus.SIG, 16'h0000);
    chk("pass_pass_n", bus.PASS_N, 1'b0);
    bus.SI_EN = 1'b0;
    bus.SI    = 1'b0;

    // Restart at compaction cycle 10
    bus.SET_EN = 1'b1;
    tick();
    bus.SET_EN = 1'b0;
    bus.Y      = 16'h00ff;
    repeat (9) tick();
    bus.Y      = 16'h0000;
    bus.SET_EN = 1'b1;
    tick();
    bus.SET_EN = 1'b0;
    chk("restart_pass_n", bus.PASS_N, 1'b1);
    chk("restart_sig_seed", bus.SIG, 16'h0000);
    repeat (23) tick();
    chk("restart_busy_23", bus.BUSY, 1'b1);
    repeat (9) tick();
    chk("restart_done_32", bus.DONE, 1'b0);
    sb.push_back('{sig: 16'h0000, pass_n: 1'b0});
    tick();
    chk("restart_done_33", bus.DONE, 1'b1);

    // Abort by reset at cycle 20
    bus.SET_EN = 1'b1;
    tick();
    bus.SET_EN = 1'b0;
    bus.Y      = 16'h1234;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sig", bus.SIG, 16'h0000);
    chk("abort_pass_n", bus.PASS_N, 1'b1);
    chk("abort_busy", bus.BUSY, 1'b0);
    chk("abort_done", bus.DONE, 1'b0);
    bus.Y = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Full fail: 0x8000 injected on compaction edge 5
    run_bist(5, 16'h8000, m);
    chk("fail_pass_n", bus.PASS_N, 1'b1);
    chk("fail_sig_model", bus.SIG, m);

    // Scan in DONE: old signature streams out MSB-first while A5C3 shifts in
    pat       = 16'hA5C3;
    bus.SI_EN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.SI = pat[15-i];
      chk($sformatf("scan_so_%0d", i), bus.SO, m[15-i]);
      tick();
    end
    bus.SI_EN = 1'b0;
    chk("scan_sig", bus.SIG, 16'hA5C3);
    chk("scan_pass_n", bus.PASS_N, 1'b1);
    chk("scan_done", bus.DONE, 1'b1);

    // Leaving test mode drops DONE but holds signature and verdict
    bus.TEST_EN = 1'b0;
    tick();
    chk("testen_done", bus.DONE, 1'b0);
    chk("testen_sig", bus.SIG, 16'hA5C3);
    chk("testen_pass_n", bus.PASS_N, 1'b1);

    tick();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
